// File: rtl/ppu_sparse_compressor.sv
// ppu_sparse_compressor: drains an accumulator region through ReLU/shift/saturate and
// zero-run encodes the results into value/index pairs written to OARAM.
module ppu_sparse_compressor #(
   parameter int BANK_COUNT  = 32,
   parameter int TILE_SIZE   = 256,
   parameter int ACC_WIDTH   = 24,
   parameter int VALUE_WIDTH = 8,
   parameter int INDEX_WIDTH = 4,
   parameter int RAM_WIDTH   = 10
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_start,
   input  logic [1:0]                     i_bitwidth,
   input  logic [4:0]                     i_shift,
   input  logic [$clog2(TILE_SIZE):0]     i_row_count,
   input  logic [$clog2(TILE_SIZE):0]     i_col_count,
   input  logic [RAM_WIDTH-1:0]           i_base_address,
   output logic [$clog2(BANK_COUNT)-1:0]  o_buffer_bank_read,
   output logic [$clog2(TILE_SIZE)-1:0]   o_buffer_row,
   output logic [$clog2(TILE_SIZE)-1:0]   o_buffer_column,
   output logic                           o_buffer_read_enable,
   input  logic [ACC_WIDTH-1:0]           i_buffer_data_read,
   output logic [VALUE_WIDTH-1:0]         o_oaram_value,
   output logic [INDEX_WIDTH-1:0]         o_oaram_index,
   output logic [RAM_WIDTH-1:0]           o_oaram_address,
   output logic                           o_oaram_write_enable,
   input  logic                           i_oaram_ready,
   output logic                           o_busy,
   output logic                           o_done,
   output logic [RAM_WIDTH:0]             o_entry_count,
   output logic                           o_address_wrapped
);
   localparam int CW = $clog2(TILE_SIZE);
   localparam int BW = $clog2(BANK_COUNT);
   localparam int EW = VALUE_WIDTH + INDEX_WIDTH;
   localparam logic [INDEX_WIDTH-1:0] RUN_MAX = '1;

   typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

   state_t                 r_state;
   logic [1:0]             r_bitwidth;
   logic [4:0]             r_shift;
   logic [CW:0]            r_rows;
   logic [CW:0]            r_cols;
   logic [CW-1:0]          r_row;
   logic [CW-1:0]          r_col;
   logic [BW-1:0]          r_bank;
   logic                   r_pend;
   logic [INDEX_WIDTH-1:0] r_run;
   logic [EW-1:0]          r_q0;
   logic [EW-1:0]          r_q1;
   logic [1:0]             r_cnt;
   logic [RAM_WIDTH-1:0]   r_addr;
   logic                   r_busy;
   logic                   r_done;
   logic [RAM_WIDTH:0]     r_count;
   logic                   r_wrapped;

   logic                   w_pop;
   logic [1:0]             w_occ;
   logic [1:0]             w_slot;
   logic                   w_rd;
   logic                   w_col_end;
   logic                   w_last;
   logic [ACC_WIDTH-1:0]   w_shifted;
   logic [ACC_WIDTH-1:0]   w_max;
   logic [VALUE_WIDTH-1:0] w_val;
   logic                   w_push;
   logic [EW-1:0]          w_entry;
   logic                   w_fin;

   // A read may issue only if the skid buffer can still absorb its result two cycles later.
   always_comb begin
      w_pop     = (r_cnt != 2'd0) && i_oaram_ready;
      w_slot    = r_cnt - {1'b0, w_pop};
      w_occ     = w_slot + {1'b0, r_pend};
      w_rd      = (r_state == READ) && (w_occ < 2'd2);
      w_col_end = {1'b0, r_col} == r_cols - (CW+1)'(1);
      w_last    = w_col_end && ({1'b0, r_row} == r_rows - (CW+1)'(1));
      w_shifted = i_buffer_data_read[ACC_WIDTH-1] ? '0 : $unsigned(i_buffer_data_read) >> r_shift;
      w_max     = r_bitwidth == 2'd3 ? ACC_WIDTH'(1)
                : ACC_WIDTH'((64'd1 << (VALUE_WIDTH >> r_bitwidth)) - 64'd1);
      w_val     = w_shifted > w_max ? VALUE_WIDTH'(w_max) : VALUE_WIDTH'(w_shifted);
      w_push    = r_pend && (w_val != '0 || r_run == RUN_MAX);
      w_entry   = {w_val, r_run};
      w_fin     = !r_pend && (r_cnt == 2'd0 || (r_cnt == 2'd1 && i_oaram_ready));
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_bitwidth <= '0;
         r_shift    <= '0;
         r_rows     <= '0;
         r_cols     <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_bank     <= '0;
         r_pend     <= 1'b0;
         r_run      <= '0;
         r_q0       <= '0;
         r_q1       <= '0;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_count    <= '0;
         r_wrapped  <= 1'b0;
      end else begin
         if (w_pop) begin
            r_q0    <= r_q1;
            r_addr  <= r_addr + RAM_WIDTH'(1);
            r_count <= r_count + (RAM_WIDTH+1)'(1);
            if (&r_addr) r_wrapped <= 1'b1;
         end
         if (w_push) begin
            if (w_slot == 2'd0) r_q0 <= w_entry;
            else r_q1 <= w_entry;
         end
         r_cnt  <= w_slot + {1'b0, w_push};
         r_pend <= w_rd;
         if (r_pend) r_run <= w_push ? '0 : r_run + INDEX_WIDTH'(1);
         if (w_rd) begin
            r_bank <= r_bank + BW'(1);
            r_col  <= w_col_end ? '0 : r_col + CW'(1);
            if (w_col_end) r_row <= r_row + CW'(1);
         end
         case (r_state)
            IDLE: if (i_start) begin
               r_bitwidth <= i_bitwidth;
               r_shift    <= i_shift;
               r_rows     <= i_row_count;
               r_cols     <= i_col_count;
               r_row      <= '0;
               r_col      <= '0;
               r_bank     <= '0;
               r_run      <= '0;
               r_addr     <= i_base_address;
               r_count    <= '0;
               r_wrapped  <= 1'b0;
               r_busy     <= 1'b1;
               // An empty region passes through the (already empty) flush step.
               r_state    <= (i_row_count == '0 || i_col_count == '0) ? FLUSH : READ;
            end
            READ: if (w_rd && w_last) r_state <= FLUSH;
            FLUSH: if (w_fin) begin
               r_state <= DONE;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_buffer_bank_read   = r_bank;
   assign o_buffer_row         = r_row;
   assign o_buffer_column      = r_col;
   assign o_buffer_read_enable = w_rd;
   assign o_oaram_value        = r_q0[EW-1:INDEX_WIDTH];
   assign o_oaram_index        = r_q0[INDEX_WIDTH-1:0];
   assign o_oaram_address      = r_addr;
   assign o_oaram_write_enable = r_cnt != 2'd0;
   assign o_busy               = r_busy;
   assign o_done               = r_done;
   assign o_entry_count        = r_count;
   assign o_address_wrapped    = r_wrapped;
endmodule

// File: tb/tb_ppu_sparse_compressor.sv
// tb_ppu_sparse_compressor: table-driven region vectors plus reset and backpressure sequences.
module tb_ppu_sparse_compressor;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  bitwidth = '0;
   logic [4:0]  shift = '0;
   logic [8:0]  row_count = '0;
   logic [8:0]  col_count = '0;
   logic [9:0]  base_address = '0;
   logic [4:0]  bank;
   logic [7:0]  row;
   logic [7:0]  col;
   logic        rd_en;
   logic [23:0] data = '0;
   logic [7:0]  val;
   logic [3:0]  idx;
   logic [9:0]  addr;
   logic        we;
   logic        ready = 1'b1;
   logic        busy;
   logic        done;
   logic [10:0] entry;
   logic        wrapped;

   ppu_sparse_compressor dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_bitwidth(bitwidth), .i_shift(shift),
      .i_row_count(row_count), .i_col_count(col_count), .i_base_address(base_address),
      .o_buffer_bank_read(bank), .o_buffer_row(row), .o_buffer_column(col),
      .o_buffer_read_enable(rd_en), .i_buffer_data_read(data),
      .o_oaram_value(val), .o_oaram_index(idx), .o_oaram_address(addr),
      .o_oaram_write_enable(we), .i_oaram_ready(ready), .o_busy(busy), .o_done(done),
      .o_entry_count(entry), .o_address_wrapped(wrapped)
   );

   always #5 clk = ~clk;

   typedef struct {
      int rows; int cols; logic [1:0] bw; logic [4:0] sh; logic [9:0] base;
      logic [63:0][23:0] acc; bit tog; int n; logic [7:0][7:0] ev; logic [7:0][3:0] ei;
      bit wrap; int lat; bit acc1;
   } vec_t;
   typedef struct { logic [7:0] v; logic [3:0] x; logic [9:0] a; int c; } wr_t;

   vec_t tv[9];
   wr_t log_q[$];
   int checks = 0, errors = 0, cyc = 0, g_cols = 1;
   logic [63:0][23:0] g_acc = '0;
   bit g_tog = 1'b0, hold = 1'b0;
   logic [21:0] held;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(int r, int c, int bw, int sh, int base, bit tog, int n, int lat, bit a1, bit wr);
      vec_t v;
      v.rows = r; v.cols = c; v.bw = 2'(bw); v.sh = 5'(sh); v.base = 10'(base);
      v.tog = tog; v.n = n; v.lat = lat; v.acc1 = a1; v.wrap = wr;
      v.acc = '0; v.ev = '0; v.ei = '0;
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rd_en) data <= g_acc[int'(row) * g_cols + int'(col)];

   initial forever begin
      @(posedge clk);
      #1 ready = g_tog ? ~ready : 1'b1;
   end

   // Observer: bank mapping, write stability under backpressure, and accepted-write log.
   initial forever begin
      @(negedge clk);
      if (rd_en) chk("bank", int'(bank), (int'(row) * g_cols + int'(col)) % 32);
      if (hold) chk("hold_stable", int'({we, val, idx, addr}), int'({1'b1, held}));
      hold = we && !ready;
      held = {val, idx, addr};
      if (we && ready) log_q.push_back('{val, idx, addr, cyc});
   end

   task automatic run(input vec_t v, input string tag);
      int s, dc;
      bit got;
      g_acc = v.acc; g_cols = v.cols; g_tog = v.tog;
      @(negedge clk);
      log_q.delete();
      bitwidth = v.bw; shift = v.sh; row_count = 9'(v.rows); col_count = 9'(v.cols);
      base_address = v.base; start = 1'b1; s = cyc;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_start"}, int'(busy), 1);
      chk({tag, "_wrap_clear"}, int'(wrapped), 0);
      chk({tag, "_count_clear"}, int'(entry), 0);
      got = 1'b0; dc = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         if (done) begin got = 1'b1; dc = cyc; end
         else @(negedge clk);
      end
      chk({tag, "_done_seen"}, int'(got), 1);
      if (got) begin
         #1;
         if (v.lat != 0) chk({tag, "_done_lat"}, dc - s, v.lat);
         chk({tag, "_n_writes"}, log_q.size(), v.n);
         chk({tag, "_entry_count"}, int'(entry), v.n);
         chk({tag, "_wrapped"}, int'(wrapped), int'(v.wrap));
         chk({tag, "_busy_done"}, int'(busy), 0);
         for (int k = 0; k < v.n && k < log_q.size(); k++) begin
            chk({tag, "_val"}, int'(log_q[k].v), int'(v.ev[k]));
            chk({tag, "_idx"}, int'(log_q[k].x), int'(v.ei[k]));
            chk({tag, "_addr"}, int'(log_q[k].a), int'(10'(v.base + 10'(k))));
         end
         if (v.acc1 && log_q.size() > 0) chk({tag, "_done_after_accept"}, dc, log_q[$].c + 1);
         @(negedge clk);
         chk({tag, "_done_pulse"}, int'(done), 0);
      end
      g_tog = 1'b0;
   endtask

   initial begin
      int dn;
      tv[0] = mk(2, 2, 0, 0, 'h010, 0, 1, 7, 0, 0);
      tv[0].acc[0] = 24'd5; tv[0].acc[3] = 24'hFFFFFD; tv[0].ev[0] = 8'd5;
      tv[1] = mk(1, 20, 0, 0, 'h020, 0, 2, 23, 1, 0);
      tv[1].acc[19] = 24'd7; tv[1].ei[0] = 4'd15; tv[1].ev[1] = 8'd7; tv[1].ei[1] = 4'd3;
      tv[2] = mk(1, 3, 1, 2, 'h100, 0, 1, 6, 0, 0);
      tv[2].acc[0] = 24'd100; tv[2].acc[1] = 24'hFFFFCE; tv[2].acc[2] = 24'd3; tv[2].ev[0] = 8'd15;
      tv[3] = mk(1, 8, 0, 0, 'h040, 1, 8, 0, 1, 0);
      for (int k = 0; k < 8; k++) begin tv[3].acc[k] = 24'd1; tv[3].ev[k] = 8'd1; end
      tv[4] = mk(1, 4, 0, 0, 'h3FE, 0, 4, 7, 1, 1);
      for (int k = 0; k < 4; k++) begin tv[4].acc[k] = 24'(k + 1); tv[4].ev[k] = 8'(k + 1); end
      tv[5] = mk(4, 16, 2, 0, 'h200, 0, 5, 67, 1, 0);
      tv[5].acc[33] = 24'd9; tv[5].acc[63] = 24'd1;
      tv[5].ei[0] = 4'd15; tv[5].ei[1] = 4'd15; tv[5].ev[2] = 8'd3; tv[5].ei[2] = 4'd1;
      tv[5].ei[3] = 4'd15; tv[5].ev[4] = 8'd1; tv[5].ei[4] = 4'd13;
      tv[6] = mk(2, 3, 3, 1, 'h050, 0, 2, 9, 0, 0);
      tv[6].acc[1] = 24'd4; tv[6].acc[2] = 24'd1; tv[6].acc[3] = 24'hFFFFF9; tv[6].acc[4] = 24'd2;
      tv[6].ev[0] = 8'd1; tv[6].ei[0] = 4'd1; tv[6].ev[1] = 8'd1; tv[6].ei[1] = 4'd2;
      tv[7] = mk(0, 5, 0, 0, 'h060, 0, 0, 2, 0, 0);
      tv[8] = mk(1, 3, 0, 20, 'h070, 0, 1, 6, 0, 0);
      tv[8].acc[0] = 24'h7FFFFF; tv[8].acc[1] = 24'h800000; tv[8].acc[2] = 24'h0FFFFF; tv[8].ev[0] = 8'd7;

      repeat (3) @(negedge clk);
      chk("reset_outputs", int'(|{bank, row, col, rd_en, val, idx, addr, we, busy, done, entry, wrapped}), 0);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) run(tv[i], $sformatf("v%0d", i));

      // Abort mid-region: ignored restart, then reset during READ.
      g_acc = '0;
      for (int k = 0; k < 16; k++) g_acc[k] = 24'd1;
      g_cols = 4;
      @(negedge clk);
      bitwidth = 2'd0; shift = 5'd0; row_count = 9'd4; col_count = 9'd4; base_address = 10'h080; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      row_count = 9'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_mid", int'(busy), 1);
      chk("read_mid", int'(rd_en), 1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_outputs", int'(|{bank, row, col, rd_en, val, idx, addr, we, busy, done, entry, wrapped}), 0);
      reset = 1'b0;
      log_q.delete();
      dn = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("abort_no_done", dn, 0);
      chk("abort_no_writes", log_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
